register_bank: RTL and testbench

//   Parametrised bank of DEPTH bus-attached registers sharing one tri-state data bus.

---
 rtl/register_bank.sv | 91 +++++++++
 tb/tb_register_bank.sv | 139 +++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Bank of DEPTH bus-attached registers on one shared tri-state data bus.
// The addressed entry can be loaded, incremented or decremented in place.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module register_bank_entry #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  wr,
  input  logic                  incr,
  input  logic                  decr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VALUE;
    else if (sel) begin
      if (wr)        q <= d;
      else if (incr) q <= q + DATA_WIDTH'(1);
      else if (decr) q <= q - DATA_WIDTH'(1);
    end
  end
endmodule

module register_bank #(
  parameter int                    DATA_WIDTH  = `DATA_WIDTH,
  parameter int                    DEPTH       = 4,
  parameter int                    ADDR_WIDTH  = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  OE,
  input  logic                  EN,
  input  logic                  INC,
  input  logic                  DEC,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  zero,
  output logic                  carry
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0]            rd_val;
  logic                             in_range, act, wr, incr, decr;

  assign in_range = {1'b0, addr} < DEPTH_L;
  assign act      = CS && !reset && in_range;
  // EN under OE would loop the bus back onto itself, so the load is dropped
  assign wr       = act && EN && !OE;
  assign incr     = act && !wr && INC && !DEC;
  assign decr     = act && !wr && DEC && !INC;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    register_bank_entry #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_entry (
      .clk  (clk),
      .reset(reset),
      .sel  (addr == ADDR_WIDTH'(i)),
      .wr   (wr),
      .incr (incr),
      .decr (decr),
      .d    (data),
      .q    (q[i])
    );
  end

  // Out-of-range addresses match no entry and read back as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++)
      if (addr == ADDR_WIDTH'(i)) rd_val = q[i];
  end

  assign zero = (rd_val == '0);
  assign data = (CS && OE && !reset) ? rd_val : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (reset) carry <= 1'b0;
    else       carry <= (incr && rd_val == '1) || (decr && rd_val == '0);
  end
endmodule

// File: tb/tb_register_bank.sv
// Directed vector bench for register_bank; a DEPTH=3 instance covers out-of-range addressing.
`timescale 1ns/1ps
module tb_register_bank;
  logic       clk = 1'b0;
  logic       reset, cs, oe, en, inc, dec;
  logic [1:0] addr;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] data, bdata;
  logic       zero, carry, bzero, bcarry;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  // A high-Z DUT bus is observed as the bench's own pattern showing through
  assign data  = drv_en ? drv : 8'hzz;
  assign bdata = drv_en ? drv : 8'hzz;

  register_bank #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .CS(cs), .OE(oe), .EN(en), .INC(inc), .DEC(dec),
    .addr(addr), .data(data), .zero(zero), .carry(carry));

  register_bank #(.DATA_WIDTH(8), .DEPTH(3), .ADDR_WIDTH(2), .RESET_VALUE(8'h00)) dut3 (
    .clk(clk), .reset(reset), .CS(cs), .OE(oe), .EN(en), .INC(inc), .DEC(dec),
    .addr(addr), .data(bdata), .zero(bzero), .carry(bcarry));

  typedef struct {
    logic       rst, cs, oe, en, inc, dec;
    logic [1:0] addr;
    logic       drv;
    logic [7:0] dval, exp_data;
    logic       exp_zero, exp_carry;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic c, logic o, logic e, logic i, logic d,
                              logic [1:0] a, logic dv, logic [7:0] val, logic [7:0] ed,
                              logic ez, logic ec, string n);
    vec_t v;
    v.rst = r; v.cs = c; v.oe = o; v.en = e; v.inc = i; v.dec = d;
    v.addr = a; v.drv = dv; v.dval = val; v.exp_data = ed;
    v.exp_zero = ez; v.exp_carry = ec; v.name = n;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; cs = 1; oe = 0; en = 0; inc = 0; dec = 0; drv_en = 0; drv = 8'h00;
  endtask

  initial begin
    logic [7:0] rd_exp [4];
    rd_exp[0] = 8'h00; rd_exp[1] = 8'hA5; rd_exp[2] = 8'h3C; rd_exp[3] = 8'h00;

    // rst cs oe en inc dec addr drv dval  -> data zero carry
    vq.push_back(mk(1,1,1,0,0,0,2'd0,1,8'h5A, 8'h5A,1,0,"rst_busz"));
    for (int a = 0; a < 4; a++)
      vq.push_back(mk(0,1,1,0,0,0,2'(a),0,8'h00, 8'h00,1,0,"rd_after_rst"));
    vq.push_back(mk(0,1,0,1,0,0,2'd1,1,8'hA5, 8'hA5,0,0,"wr_a1"));
    vq.push_back(mk(0,1,0,1,0,0,2'd2,1,8'h3C, 8'h3C,0,0,"wr_a2"));
    for (int a = 0; a < 4; a++)
      vq.push_back(mk(0,1,1,0,0,0,2'(a),0,8'h00, rd_exp[a],(rd_exp[a] == 8'h00),0,"rd_after_wr"));
    vq.push_back(mk(0,1,0,1,0,0,2'd3,1,8'hFE, 8'hFE,0,0,"wr_a3"));
    vq.push_back(mk(0,1,1,0,1,0,2'd3,0,8'h00, 8'hFF,0,0,"inc_ff"));
    vq.push_back(mk(0,1,1,0,1,0,2'd3,0,8'h00, 8'h00,1,1,"inc_wrap"));
    vq.push_back(mk(0,1,1,0,0,0,2'd3,0,8'h00, 8'h00,1,0,"carry_clr"));
    vq.push_back(mk(0,1,1,0,0,1,2'd3,0,8'h00, 8'hFF,0,1,"dec_wrap"));
    vq.push_back(mk(0,1,1,0,0,0,2'd3,0,8'h00, 8'hFF,0,0,"rd_a3"));
    vq.push_back(mk(0,1,1,1,0,0,2'd1,0,8'h00, 8'hA5,0,0,"en_with_oe"));
    vq.push_back(mk(0,1,1,0,1,1,2'd3,0,8'h00, 8'hFF,0,0,"inc_and_dec"));
    vq.push_back(mk(0,1,1,1,1,0,2'd0,0,8'h00, 8'h01,0,0,"inc_under_oe"));
    vq.push_back(mk(0,0,1,1,1,0,2'd1,1,8'h11, 8'h11,0,0,"cs_low"));
    vq.push_back(mk(0,1,1,0,0,0,2'd1,0,8'h00, 8'hA5,0,0,"rd_after_cs_low"));
    vq.push_back(mk(1,1,1,1,0,0,2'd1,1,8'h5A, 8'h5A,1,0,"rst_mid"));
    for (int a = 0; a < 4; a++)
      vq.push_back(mk(0,1,1,0,0,0,2'(a),0,8'h00, 8'h00,1,0,"rd_after_rst_mid"));

    idle(); addr = 0;
    @(negedge clk);
    foreach (vq[k]) begin
      reset = vq[k].rst; cs = vq[k].cs; oe = vq[k].oe; en = vq[k].en;
      inc = vq[k].inc; dec = vq[k].dec; addr = vq[k].addr;
      drv_en = vq[k].drv; drv = vq[k].dval;
      @(negedge clk);
      if (vq[k].drv || (vq[k].cs && vq[k].oe && !vq[k].rst))
        chk({vq[k].name, ".data"}, data, vq[k].exp_data);
      chk({vq[k].name, ".zero"},  {7'd0, zero},  {7'd0, vq[k].exp_zero});
      chk({vq[k].name, ".carry"}, {7'd0, carry}, {7'd0, vq[k].exp_carry});
    end

    // zero and read data follow addr with no clock edge
    idle(); en = 1; addr = 2; drv_en = 1; drv = 8'h01;
    @(negedge clk);
    idle(); addr = 2; #1;
    chk("zero_addr2", {7'd0, zero}, 8'h00);
    addr = 0; #1;
    chk("zero_addr0", {7'd0, zero}, 8'h01);
    oe = 1; addr = 2; #1;
    chk("rd_comb_addr2", data, 8'h01);

    // carry pulse is cleared by a following write
    idle(); oe = 1; dec = 1; addr = 0;
    @(negedge clk);
    chk("dec0_carry", {7'd0, carry}, 8'h01);
    chk("dec0_data", data, 8'hFF);
    idle(); en = 1; addr = 0; drv_en = 1; drv = 8'h10;
    @(negedge clk);
    chk("wr_clears_carry", {7'd0, carry}, 8'h00);
    idle(); oe = 1; addr = 0;
    @(negedge clk);
    chk("rd_a0_after_wr", data, 8'h10);

    // DEPTH=3 bank: addr 3 is out of range
    idle(); en = 1; addr = 3; drv_en = 1; drv = 8'h77;
    @(negedge clk);
    chk("d3_wr_oor_carry", {7'd0, bcarry}, 8'h00);
    idle(); oe = 1; addr = 3; #1;
    chk("d3_rd_oor_data", bdata, 8'h00);
    chk("d3_rd_oor_zero", {7'd0, bzero}, 8'h01);
    dec = 1;
    @(negedge clk);
    chk("d3_dec_oor_carry", {7'd0, bcarry}, 8'h00);
    chk("d3_dec_oor_data", bdata, 8'h00);
    idle(); oe = 1; addr = 1; #1;
    chk("d3_rd_a1", bdata, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
